// File: rtl/eth_mac_rx.sv
// Receive-side Ethernet MAC deframer: preamble/SFD hunt, FCS stripping through a
// 4-byte delay line, CRC-32 residue and length checks, one-cycle end-of-frame status.
module eth_mac_rx #(
   parameter int MIN_PRE_BYTES = 7,
   parameter int MIN_FRAME     = 64,
   parameter int MAX_FRAME     = 1518
) (
   input  logic       clock,
   input  logic       in_reset_n,
   input  logic       in_rxen,
   input  logic [7:0] in_rxd,
   output logic       out_dll_rxen,
   output logic [7:0] out_dll_rxd,
   output logic       out_frame_done,
   output logic       out_frame_ok,
   output logic       out_crc_err,
   output logic       out_len_err,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

   localparam logic [3:0]  MIN_PRE  = 4'(MIN_PRE_BYTES);
   localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
   // Byte k leaves the delay line while len == k+4, so this stops after byte MAX_FRAME-1.
   localparam logic [10:0] FWD_LIM  = 11'(MAX_FRAME + 4);
   localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

   state_t      state, state_nxt;
   logic [3:0]  pre_cnt;
   logic [10:0] len;
   logic [31:0] crc;
   logic [7:0]  dly [4];
   logic        start_frame, push, frame_end;
   logic        crc_bad, len_bad;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign dbg_state = state;
   assign crc_bad   = (crc != RESIDUE);
   assign len_bad   = (len < MIN_LEN) || (len > MAX_LEN);

   always_ff @(posedge clock or negedge in_reset_n) begin
      if (!in_reset_n) state <= S_IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      push        = 1'b0;
      frame_end   = 1'b0;
      case (state)
         S_IDLE:
            if (in_rxen) state_nxt = (in_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
         S_PREAMBLE:
            if (!in_rxen)
               state_nxt = S_IDLE;
            else if (in_rxd == 8'h55)
               state_nxt = S_PREAMBLE;
            else if (in_rxd == 8'hD5 && pre_cnt >= MIN_PRE) begin
               state_nxt   = S_DATA;
               start_frame = 1'b1;
            end else
               state_nxt = S_DROP;
         S_DATA:
            if (in_rxen) push = 1'b1;
            else begin
               state_nxt = S_IDLE;
               frame_end = 1'b1;
            end
         S_DROP:
            if (!in_rxen) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         pre_cnt        <= 4'd0;
         len            <= 11'd0;
         crc            <= 32'hFFFFFFFF;
         for (int i = 0; i < 4; i++) dly[i] <= 8'h00;
         out_dll_rxen   <= 1'b0;
         out_dll_rxd    <= 8'h00;
         out_frame_done <= 1'b0;
         out_frame_ok   <= 1'b0;
         out_crc_err    <= 1'b0;
         out_len_err    <= 1'b0;
      end else begin
         out_dll_rxen   <= 1'b0;
         out_frame_done <= 1'b0;
         out_frame_ok   <= 1'b0;
         out_crc_err    <= 1'b0;
         out_len_err    <= 1'b0;
         if (state == S_IDLE && in_rxen && in_rxd == 8'h55)
            pre_cnt <= 4'd1;
         if (state == S_PREAMBLE && in_rxen && in_rxd == 8'h55 && pre_cnt != 4'hF)
            pre_cnt <= pre_cnt + 4'd1;
         if (start_frame) begin
            crc <= 32'hFFFFFFFF;
            len <= 11'd0;
            for (int i = 0; i < 4; i++) dly[i] <= 8'h00;
         end
         if (push) begin
            crc    <= crc_byte(crc, in_rxd);
            if (len != 11'h7FF) len <= len + 11'd1;
            dly[0] <= in_rxd;
            dly[1] <= dly[0];
            dly[2] <= dly[1];
            dly[3] <= dly[2];
            // The line is full once four bytes are in; the oldest then goes out.
            if (len >= 11'd4 && len < FWD_LIM) begin
               out_dll_rxen <= 1'b1;
               out_dll_rxd  <= dly[3];
            end
         end
         if (frame_end) begin
            out_frame_done <= 1'b1;
            out_crc_err    <= crc_bad;
            out_len_err    <= len_bad;
            out_frame_ok   <= !crc_bad && !len_bad;
         end
      end
   end

endmodule

// File: tb/tb_eth_mac_rx.sv
// Bench for eth_mac_rx: frames built with a software CRC-32, forwarded bytes and
// end-of-frame status checked against expected queues filled as stimulus is driven.
module tb_eth_mac_rx;

   localparam int MAX_FRAME = 1518;
   localparam int MIN_FRAME = 64;

   logic       clock = 1'b0;
   logic       in_reset_n = 1'b0;
   logic       in_rxen = 1'b0;
   logic [7:0] in_rxd = 8'h00;
   logic       out_dll_rxen;
   logic [7:0] out_dll_rxd;
   logic       out_frame_done, out_frame_ok, out_crc_err, out_len_err;
   logic [1:0] dbg_state;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         exp_t[$];
   logic [2:0] st_q[$];
   logic [7:0] frm[$];

   eth_mac_rx dut (
      .clock          (clock),
      .in_reset_n     (in_reset_n),
      .in_rxen        (in_rxen),
      .in_rxd         (in_rxd),
      .out_dll_rxen   (out_dll_rxen),
      .out_dll_rxd    (out_dll_rxd),
      .out_frame_done (out_frame_done),
      .out_frame_ok   (out_frame_ok),
      .out_crc_err    (out_crc_err),
      .out_len_err    (out_len_err),
      .dbg_state      (dbg_state)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] crc32_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // n data bytes (k mod 256), FCS over the clean data, then optional corruption.
   task automatic build_frame(input int n, input int bad_idx);
      logic [31:0] c;
      logic [31:0] fcs;
      frm.delete();
      c = 32'hFFFFFFFF;
      for (int k = 0; k < n; k++) begin
         frm.push_back(8'(k));
         c = crc32_upd(c, 8'(k));
      end
      if (bad_idx >= 0) frm[bad_idx] = 8'hFF;
      fcs = ~c;
      frm.push_back(fcs[7:0]);
      frm.push_back(fcs[15:8]);
      frm.push_back(fcs[23:16]);
      frm.push_back(fcs[31:24]);
   endtask

   // One cycle: score the outputs at the falling edge, then drive the next wire byte.
   task automatic step(input logic rxen, input logic [7:0] d, input bit expect_byte);
      logic [7:0] eb;
      int         et;
      logic [2:0] es;
      @(negedge clock);
      if (out_dll_rxen === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL dll_unexpected: got byte %02h at cycle %0d, required none", out_dll_rxd, cyc);
         end else begin
            eb = exp_q.pop_front();
            et = exp_t.pop_front();
            if (out_dll_rxd !== eb) begin
               n_err++;
               $display("FAIL dll_data: got %02h, required %02h (cycle %0d)", out_dll_rxd, eb, cyc);
            end
            n_cmp++;
            if (cyc !== et) begin
               n_err++;
               $display("FAIL dll_latency: byte %02h at cycle %0d, required cycle %0d", eb, cyc, et);
            end
         end
      end
      n_cmp++;
      if (out_frame_done === 1'b1) begin
         if (st_q.size() == 0) begin
            n_err++;
            $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
         end else begin
            es = st_q.pop_front();
            if ({out_frame_ok, out_crc_err, out_len_err} !== es) begin
               n_err++;
               $display("FAIL status: got ok/crc/len=%b, required %b", {out_frame_ok, out_crc_err, out_len_err}, es);
            end
         end
      end else if ({out_frame_ok, out_crc_err, out_len_err} !== 3'b000) begin
         n_err++;
         $display("FAIL flags_without_done: got %b, required 000", {out_frame_ok, out_crc_err, out_len_err});
      end
      if (expect_byte) begin
         exp_q.push_back(d);
         exp_t.push_back(cyc + 5);
      end
      in_rxen = rxen;
      in_rxd  = d;
   endtask

   task automatic send_burst(input int npre, input logic [7:0] sfd, input bit valid, input bit crc_bad);
      int  total;
      bit  lerr;
      total = frm.size();
      lerr  = (total < MIN_FRAME) || (total > MAX_FRAME);
      if (valid) st_q.push_back({!crc_bad && !lerr, crc_bad, lerr});
      for (int i = 0; i < npre; i++) step(1'b1, 8'h55, 1'b0);
      step(1'b1, sfd, 1'b0);
      for (int k = 0; k < total; k++)
         step(1'b1, frm[k], valid && (k < total - 4) && (k < MAX_FRAME));
      step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain(input string name);
      repeat (12) step(1'b0, 8'h00, 1'b0);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_bytes_left: got %0d unforwarded, required 0", name, exp_q.size());
      end
      n_cmp++;
      if (st_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_done_missing: got %0d pending status, required 0", name, st_q.size());
      end
      exp_q.delete();
      exp_t.delete();
      st_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({out_dll_rxen, out_frame_done, out_frame_ok, out_crc_err, out_len_err} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b, required 00000",
                  {out_dll_rxen, out_frame_done, out_frame_ok, out_crc_err, out_len_err});
      end
      n_cmp++;
      if (out_dll_rxd !== 8'h00) begin
         n_err++;
         $display("FAIL reset_rxd: got %02h, required 00", out_dll_rxd);
      end
      n_cmp++;
      if (dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_state: got %0d, required 0", dbg_state);
      end
      in_reset_n = 1'b1;
   endtask

   task automatic test_good_frame();
      build_frame(60, -1);
      send_burst(7, 8'hD5, 1'b1, 1'b0);
      drain("good");
   endtask

   task automatic test_crc_error();
      build_frame(60, 10);
      send_burst(7, 8'hD5, 1'b1, 1'b1);
      drain("crc_err");
   endtask

   task automatic test_runt();
      build_frame(20, -1);
      send_burst(9, 8'hD5, 1'b1, 1'b0);
      drain("runt");
   endtask

   task automatic test_bad_preamble();
      build_frame(60, -1);
      send_burst(3, 8'hD5, 1'b0, 1'b0);
      send_burst(7, 8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h12, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < 70; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      drain("bad_preamble");
   endtask

   task automatic test_oversize();
      build_frame(1526, -1);
      send_burst(7, 8'hD5, 1'b1, 1'b0);
      drain("oversize");
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         build_frame($urandom_range(60, 120), (f == 1) ? 5 : -1);
         send_burst($urandom_range(7, 15), 8'hD5, 1'b1, f == 1);
      end
      drain("back_to_back");
   endtask

   task automatic test_reset_mid_frame();
      build_frame(60, -1);
      for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'hD5, 1'b0);
      // Byte 25 emerges on the edge that samples byte 29 and is wiped by the reset.
      for (int k = 0; k < 30; k++) step(1'b1, frm[k], k < 25);
      @(posedge clock);
      #2;
      in_reset_n = 1'b0;
      in_rxen    = 1'b0;
      in_rxd     = 8'h00;
      #1;
      n_cmp++;
      if ({out_dll_rxen, out_frame_done, out_frame_ok, out_crc_err, out_len_err} !== 5'b0) begin
         n_err++;
         $display("FAIL midreset_flags: got %b, required 00000",
                  {out_dll_rxen, out_frame_done, out_frame_ok, out_crc_err, out_len_err});
      end
      n_cmp++;
      if (out_dll_rxd !== 8'h00 || dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL midreset_state: got rxd=%02h state=%0d, required 00/0", out_dll_rxd, dbg_state);
      end
      repeat (2) @(negedge clock);
      in_reset_n = 1'b1;
      drain("midreset_quiet");
      send_burst(7, 8'hD5, 1'b1, 1'b0);
      drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_crc_error();
      test_runt();
      test_bad_preamble();
      test_oversize();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
